booth_seq_mul: RTL and testbench

Sequential radix-2 Booth multiplier controller for the UAL multiply path. It accepts one signed 4x4 operand pair over a valid/ready handshake, applies one Booth add/subtract step and one arithmetic shift per clock for 4 clocks, and presents the signed 8-bit product over a second valid/ready handshake. One adder/subtractor path is reused across all steps, replacing the unrolled combinational multiplier when area matters more than latency.

---
 rtl/booth_seq_mul.sv | 119 +++++++++++
 tb/tb_booth_seq_mul.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// booth_seq_mul
// Sequential radix-2 Booth multiplier for signed 4x4 operands. It accepts one
// operand pair, runs four Booth steps through a single shared adder, and then
// presents the signed 8-bit product.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair M/R is valid
//   in_ready   block can accept an operand pair (IDLE)
//   M, R       multiplicand / multiplier, two's complement, 4 bits
//   out_valid  product on out is valid (DONE)
//   out_ready  consumer accepts the product
//   out        signed product M*R, 8 bits, held stable until the next result
//   busy       high in CALC or DONE
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one Booth add/subtract plus arithmetic shift per clock, 4 clocks
// DONE  | product presented, waiting for out_ready
module booth_seq_mul (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] M,
    input  logic [3:0] R,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [9:0] p;
    logic [9:0] a;
    logic [9:0] s;
    logic [9:0] p_sum;
    logic [9:0] p_step;
    logic [4:0] m_ext;
    logic [4:0] m_neg;
    logic       accept;
    logic       last_step;

    // Sign-extending to 5 bits before negating keeps M = -8 representable.
    assign m_ext     = {M[3], M};
    assign m_neg     = ~m_ext + 5'd1;
    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == CALC) && (cnt == 2'd3);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)  state_nxt = CALC;
            CALC: if (cnt == 2'd3) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Booth step: the recoding pair P[1:0] selects add A, add S or nothing,
    // followed by an arithmetic shift right of the full 10-bit register.
    always_comb begin
        unique case (p[1:0])
            2'b01:   p_sum = p + a;
            2'b10:   p_sum = p + s;
            default: p_sum = p;
        endcase
        p_step = {p_sum[9], p_sum[9:1]};
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            a   <= '0;
            s   <= '0;
            cnt <= '0;
            out <= '0;
        end else if (accept) begin
            p   <= {5'b0, R, 1'b0};
            a   <= {m_ext, 5'b0};
            s   <= {m_neg, 5'b0};
            cnt <= '0;
        end else if (state == CALC) begin
            p   <= p_step;
            cnt <= cnt + 2'd1;
            if (last_step) begin
                out <= p_step[8:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
module tb_booth_seq_mul;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] M = '0;
    logic [3:0] R = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       busy;

    booth_seq_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .R         (R),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          acc_q[$];
    bit          rand_ready = 1'b0;
    bit          stop_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: plain signed integer multiply, truncated to 8 bits.
    function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] r);
        int mi;
        int ri;
        int pr;
        mi = $signed(m);
        ri = $signed(r);
        pr = mi * ri;
        return pr[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: latency on every rising out_valid, value on every handshake.
    initial begin
        bit prev_valid;
        int acc;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    n_cmp++;
                    if (acc_q.size() == 0) begin
                        n_err++;
                        $display("FAIL latency: out_valid rose with no accepted pair (cycle %0d)", cyc);
                    end else begin
                        acc = acc_q.pop_front();
                        if (cyc - acc != 4) begin
                            n_err++;
                            $display("FAIL latency: got %0d clocks expected 4", cyc - acc);
                        end
                    end
                end
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL product: unexpected output %0h with empty scoreboard", out);
                    end else begin
                        e = exp_q.pop_front();
                        if (out !== e) begin
                            n_err++;
                            $display("FAIL product: got %0h expected %0h (cycle %0d)", out, e, cyc);
                        end
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    // Random backpressure generator
    initial begin
        while (!stop_rand) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_txn(input logic [3:0] m, input logic [3:0] r, input bit keep, output int acc);
        int k;
        M = m;
        R = r;
        in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept: in_ready never seen, got 0 expected 1");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(ref_mul(m, r));
        acc_q.push_back(acc);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        if (k == 20) chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && in_ready && !out_valid) break;
        end
        if (k == 400) chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        int acc1;
        logic [3:0] tm;
        logic [3:0] tr;

        #1;
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic product
        out_ready = 1'b1;
        do_txn(4'd3, 4'd2, 1'b0, acc0);
        wait_valid();
        chk("basic_out", 32'(out), 32'h06);
        @(posedge clk);
        #1;
        chk("basic_in_ready", 32'(in_ready), 32'd1);
        chk("basic_valid_drop", 32'(out_valid), 32'd0);
        wait_drain();

        // Corner operand pairs
        do_txn(4'h8, 4'h8, 1'b0, acc0); wait_drain();
        do_txn(4'h8, 4'h7, 1'b0, acc0); wait_drain();
        do_txn(4'h7, 4'h8, 1'b0, acc0); wait_drain();
        do_txn(4'hF, 4'hF, 1'b0, acc0); wait_drain();
        do_txn(4'h0, 4'hB, 1'b0, acc0); wait_drain();

        // Backpressure
        out_ready = 1'b0;
        do_txn(4'd5, 4'hD, 1'b0, acc0);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            chk("bp_out", 32'(out), 32'hF1);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'(out_valid), 32'd0);
        chk("bp_hold_out", 32'(out), 32'hF1);
        wait_drain();

        // Busy-time input changes
        do_txn(4'd6, 4'd5, 1'b0, acc0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("busy_flag", 32'(busy), 32'd1);
            in_valid = ~in_valid;
            M = 4'($urandom);
            R = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("busy_out", 32'(out), 32'h1E);
        wait_drain();

        // Reset mid-CALC
        do_txn(4'd7, 4'd7, 1'b0, acc0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'h00);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        do_txn(4'd2, 4'hC, 1'b0, acc0);
        wait_valid();
        chk("postrst_out", 32'(out), 32'hF8);
        wait_drain();

        // Back-to-back with in_valid held high
        do_txn(4'h9, 4'd3, 1'b1, acc0);
        do_txn(4'd4, 4'hE, 1'b1, acc1);
        in_valid = 1'b0;
        chk("b2b_interval", 32'(acc1 - acc0), 32'd6);
        wait_drain();

        // All 256 pairs
        for (int i = 0; i < 256; i++) begin
            tm = 4'(i >> 4);
            tr = 4'(i);
            do_txn(tm, tr, 1'b1, acc0);
        end
        in_valid = 1'b0;
        wait_drain();

        // Random pairs with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tm = 4'($urandom);
            tr = 4'($urandom);
            do_txn(tm, tr, 1'($urandom_range(0, 1)), acc0);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        stop_rand = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
